// File: rtl/bus_map_pkg.sv
// Bus map shared by the memory-side responder and its RAM.
// Holds the address region codes, the blank seven-segment pattern and the
// data/peripheral width constants.
package bus_map_pkg;

    localparam int RAM_AW = 8;
    localparam int DW     = 16;
    localparam int LED_W  = 10;
    localparam int SW_W   = 10;
    localparam int HEX_W  = 7;
    localparam int HEX_N  = 6;

    localparam logic [3:0] REG_RAM  = 4'h0;
    localparam logic [3:0] REG_LED  = 4'h1;
    localparam logic [3:0] REG_HEX  = 4'h2;
    localparam logic [3:0] REG_SW   = 4'h3;
    // Unmapped code used as the reset value of the pipelined region, so that
    // din selects the (reset) peripheral register rather than the RAM output.
    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [HEX_W-1:0] HEX_BLANK = 7'h7F;

endpackage

// File: rtl/ram_256x16.sv
// Single-port synchronous RAM, 2**AW words of DW bits.
// Ports:
//   clk   - clock
//   we    - write enable, commits wdata to addr at the rising edge
//   addr  - word address
//   wdata - write data
//   rdata - registered read data (old contents on a same-address write)
// No reset, so contents survive a system reset and it maps onto block RAM.
module ram_256x16 #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the processor address/data bus.
// Decodes addr[15:12] into RAM, LED, HEX and switch regions; writes commit on
// the clock edge where w=1, reads return on din one cycle after addr.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   addr, dout, w    - bus address, write data, write enable from the processor
//   din              - registered read data to the processor
//   sw               - raw board switches (asynchronous)
//   ledr             - LED register
//   hex0..hex5       - seven-segment registers, active-low segments
module mem_bus_responder
    import bus_map_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     addr,
    input  logic [DW-1:0]     dout,
    input  logic              w,
    output logic [DW-1:0]     din,
    input  logic [SW_W-1:0]   sw,
    output logic [LED_W-1:0]  ledr,
    output logic [HEX_W-1:0]  hex0,
    output logic [HEX_W-1:0]  hex1,
    output logic [HEX_W-1:0]  hex2,
    output logic [HEX_W-1:0]  hex3,
    output logic [HEX_W-1:0]  hex4,
    output logic [HEX_W-1:0]  hex5
);

    logic [3:0]       region;
    logic [3:0]       region_q;
    logic             ram_we;
    logic             led_we;
    logic             hex_we;
    logic [DW-1:0]    ram_rdata;
    logic [DW-1:0]    periph_next;
    logic [DW-1:0]    periph_q;
    logic [LED_W-1:0] ledr_q;
    logic [HEX_W-1:0] hex_reg [HEX_N];
    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;

    // RAM aliases across addr[11:8].
    logic unused_addr;
    assign unused_addr = ^addr[11:8];

    assign region = addr[15:12];
    assign ram_we = w && (region == REG_RAM);
    assign led_we = w && (region == REG_LED);
    assign hex_we = w && (region == REG_HEX);

    ram_256x16 #(
        .AW (RAM_AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr[RAM_AW-1:0]),
        .wdata (dout),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledr_q <= '0;
            for (int i = 0; i < HEX_N; i++) begin
                hex_reg[i] <= HEX_BLANK;
            end
        end else begin
            if (led_we) begin
                ledr_q <= dout[LED_W-1:0];
            end
            // Indices 6 and 7 match no register, so those writes fall away.
            for (int i = 0; i < HEX_N; i++) begin
                if (hex_we && (addr[2:0] == 3'(i))) begin
                    hex_reg[i] <= dout[HEX_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Peripheral read value is built from current register contents, so a
    // write in the same cycle is seen only on the following sample.
    always_comb begin
        periph_next = '0;
        case (region)
            REG_LED: periph_next = {{(DW-LED_W){1'b0}}, ledr_q};
            REG_HEX: begin
                for (int i = 0; i < HEX_N; i++) begin
                    if (addr[2:0] == 3'(i)) begin
                        periph_next = {{(DW-HEX_W){1'b0}}, hex_reg[i]};
                    end
                end
            end
            REG_SW:  periph_next = {{(DW-SW_W){1'b0}}, sw_sync};
            default: periph_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            periph_q <= '0;
            region_q <= REG_NONE;
        end else begin
            periph_q <= periph_next;
            region_q <= region;
        end
    end

    // Both mux inputs and the select are flops: no input reaches din
    // combinationally, and reset forces the peripheral leg (zero).
    assign din  = (region_q == REG_RAM) ? ram_rdata : periph_q;

    assign ledr = ledr_q;
    assign hex0 = hex_reg[0];
    assign hex1 = hex_reg[1];
    assign hex2 = hex_reg[2];
    assign hex3 = hex_reg[3];
    assign hex4 = hex_reg[4];
    assign hex5 = hex_reg[5];

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic [15:0] din;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    mem_bus_responder dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .dout  (dout),
        .w     (w),
        .din   (din),
        .sw    (sw),
        .ledr  (ledr),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .hex3  (hex3),
        .hex4  (hex4),
        .hex5  (hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_hex(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3,
                           input logic [6:0] e4, input logic [6:0] e5);
        chk({tag, "_hex0"}, {9'b0, hex0}, {9'b0, e0});
        chk({tag, "_hex1"}, {9'b0, hex1}, {9'b0, e1});
        chk({tag, "_hex2"}, {9'b0, hex2}, {9'b0, e2});
        chk({tag, "_hex3"}, {9'b0, hex3}, {9'b0, e3});
        chk({tag, "_hex4"}, {9'b0, hex4}, {9'b0, e4});
        chk({tag, "_hex5"}, {9'b0, hex5}, {9'b0, e5});
    endtask

    // Present a read address, push the expected value, compare one cycle later.
    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] e);
        addr = a;
        w    = 1'b0;
        exp_q.push_back(e);
        tick();
        chk(tag, din, exp_q.pop_front());
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr = a;
        dout = d;
        w    = 1'b1;
        tick();
        w    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        addr  = 16'h8000;
        dout  = 16'h0000;
        w     = 1'b0;
        sw    = 10'h000;
        tick();
        tick();
        chk("rst_din", din, 16'h0000);
        chk("rst_ledr", {6'b0, ledr}, 16'h0000);
        chk_hex("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        reset = 1'b0;
        tick();

        // RAM write then exact one-cycle read latency, and alias.
        wr(16'h0012, 16'hBEEF);
        rd("pre_unmapped", 16'h8000, 16'h0000);
        rd("ram_rd", 16'h0012, 16'hBEEF);
        rd("ram_alias", 16'h0F12, 16'hBEEF);

        for (int i = 0; i < 4; i++) begin
            wr(16'h0020 + 16'(i), 16'hA500 + 16'(i * 17));
        end
        for (int i = 0; i < 4; i++) begin
            rd("ram_pattern", 16'h0320 + 16'(i), 16'hA500 + 16'(i * 17));
        end

        // Read-during-write returns the old contents first.
        wr(16'h0005, 16'h1111);
        addr = 16'h0005;
        dout = 16'h2222;
        w    = 1'b1;
        exp_q.push_back(16'h1111);
        tick();
        chk("rdw_old", din, exp_q.pop_front());
        w = 1'b0;
        exp_q.push_back(16'h2222);
        tick();
        chk("rdw_new", din, exp_q.pop_front());

        // LED register updates on the write edge.
        wr(16'h1000, 16'h03FF);
        chk("ledr_write", {6'b0, ledr}, 16'h03FF);
        rd("ledr_read", 16'h1000, 16'h03FF);

        // HEX registers.
        wr(16'h2005, 16'h0040);
        chk_hex("hex5_wr", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
        wr(16'h2006, 16'h0011);
        chk_hex("hex6_wr", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
        wr(16'h2000, 16'h0079);
        chk_hex("hex0_wr", 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
        rd("hex6_read", 16'h2006, 16'h0000);
        rd("hex5_read", 16'h2005, 16'h0040);
        rd("hex0_read", 16'h2000, 16'h0079);

        // Switch synchronizer: not visible after one edge, visible after three.
        addr = 16'h3000;
        sw   = 10'h2A5;
        tick();
        chk("sw_early", din, 16'h0000);
        tick();
        tick();
        chk("sw_sync", din, 16'h02A5);
        wr(16'h3000, 16'hFFFF);
        rd("sw_after_wr", 16'h3000, 16'h02A5);
        chk("sw_wr_ledr", {6'b0, ledr}, 16'h03FF);

        // Unmapped region.
        wr(16'h8000, 16'hFFFF);
        chk("unmap_ledr", {6'b0, ledr}, 16'h03FF);
        chk_hex("unmap", 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
        rd("unmap_read", 16'h8000, 16'h0000);
        rd("unmap_ram", 16'h0012, 16'hBEEF);

        // Mid-cycle reset acts immediately; RAM keeps its contents.
        rd("pre_reset", 16'h0012, 16'hBEEF);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_din", din, 16'h0000);
        chk("midrst_ledr", {6'b0, ledr}, 16'h0000);
        chk_hex("midrst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        tick();
        reset = 1'b0;
        rd("post_rst_sw", 16'h3000, 16'h0000);
        rd("ram_kept", 16'h0012, 16'hBEEF);
        rd("ram_kept2", 16'h0005, 16'h2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
